// File: rtl/frame_ctr_pkg.sv
// Shared types and widths for the frame sequencer and its readout FIFO.
package frame_ctr_pkg;
  localparam int ADDR_W = 18;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    READ = 2'd2
  } state_e;
endpackage

// File: rtl/frame_ctr_a_rd_skid_fifo.sv
// Two-entry FIFO that absorbs the BRAM read latency in front of the consumer.
module rd_skid_fifo
  import frame_ctr_pkg::*;
#(
  parameter int W = DATA_W + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic [1:0]   occ_o,
  output logic         full_o,
  output logic         empty_o
);
  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   occ_q;
  logic [1:0]   occ_d;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop_i && (occ_q != 2'd0);
  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign do_push = push_i && ((occ_q != 2'd2) || do_pop);

  always_comb begin
    occ_d = occ_q;
    case ({do_push, do_pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      occ_q <= occ_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign occ_o   = occ_q;
  assign full_o  = (occ_q == 2'd2);
  assign empty_o = (occ_q == 2'd0);
endmodule

// File: rtl/frame_ctr_a.sv
// Frame sequencer: fills the pixel BRAM with one raster frame, then streams it
// back in raster order over valid/ready, owning the single BRAM port throughout.
module frame_ctr_a
  import frame_ctr_pkg::*;
#(
  parameter int unsigned MAX_ROW = 360,
  parameter int unsigned MAX_COL = 540
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [DATA_W-1:0] pixel_i,
  input  logic              pixel_en_i,
  output logic              ena_o,
  output logic              wea_o,
  output logic [ADDR_W-1:0] addra_o,
  output logic [DATA_W-1:0] d2mema_o,
  input  logic [DATA_W-1:0] mem2da_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  input  logic              rd_ready_i,
  output logic              rd_last_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);
  localparam int unsigned FRAME_PIX = MAX_ROW * MAX_COL;
  localparam int          CNT_W     = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(FRAME_PIX - 1);

  state_e           state_q;
  // One bit wider than the BRAM address so "all reads issued" is representable.
  logic [CNT_W-1:0] addr_q;
  logic             inflight_q;
  logic             inflight_last_q;
  logic             err_q;
  logic             done_q;

  logic [DATA_W:0]  fifo_head;
  logic [1:0]       fifo_occ;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             final_xfer;
  logic             issue;
  logic [2:0]       pending;

  assign pop        = ~fifo_empty & rd_ready_i;
  assign final_xfer = (state_q == READ) & pop & fifo_head[DATA_W];
  assign pending    = {1'b0, fifo_occ} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue      = (state_q == READ) && (addr_q <= LAST_ADDR) &&
                      (pending < 3'd2) && !(fifo_full && !pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      err_q           <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      done_q          <= 1'b0;
      inflight_q      <= issue;
      inflight_last_q <= issue && (addr_q == LAST_ADDR);
      if (pixel_en_i && (state_q != FILL)) begin
        err_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          addr_q <= '0;
          if (start_i) begin
            state_q <= FILL;
            err_q   <= 1'b0;
          end
        end
        FILL: begin
          if (pixel_en_i) begin
            if (addr_q == LAST_ADDR) begin
              addr_q  <= '0;
              state_q <= READ;
            end else begin
              addr_q <= addr_q + 1'b1;
            end
          end
        end
        READ: begin
          if (issue) begin
            addr_q <= addr_q + 1'b1;
          end
          if (final_xfer) begin
            state_q <= IDLE;
            addr_q  <= '0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Write path is combinational so a pixel reaches the BRAM in its own cycle.
  always_comb begin
    ena_o    = 1'b0;
    wea_o    = 1'b0;
    d2mema_o = '0;
    case (state_q)
      FILL: begin
        ena_o    = pixel_en_i;
        wea_o    = 1'b1;
        d2mema_o = pixel_en_i ? pixel_i : '0;
      end
      READ:    ena_o = issue;
      default: ena_o = 1'b0;
    endcase
  end

  assign addra_o = addr_q[ADDR_W-1:0];

  rd_skid_fifo #(.W(DATA_W + 1)) u_rd_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q),
    .push_data_i ({inflight_last_q, mem2da_i}),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .occ_o       (fifo_occ),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign rd_valid_o = ~fifo_empty;
  assign rd_data_o  = fifo_empty ? '0 : fifo_head[DATA_W-1:0];
  assign rd_last_o  = ~fifo_empty & fifo_head[DATA_W];
  assign busy_o     = (state_q != IDLE);
  assign done_o     = done_q;
  assign err_o      = err_q;
endmodule

// File: tb/tb_frame_ctr_a.sv
// Scoreboard bench for frame_ctr_a on a 4x4 frame with a behavioural BRAM.
module tb_frame_ctr_a;
  localparam int NPIX = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [7:0]  pixel_i;
  logic        pixel_en_i;
  logic        ena_o;
  logic        wea_o;
  logic [17:0] addra_o;
  logic [7:0]  d2mema_o;
  logic [7:0]  mem2da_i = 8'h00;
  logic [7:0]  rd_data_o;
  logic        rd_valid_o;
  logic        rd_ready_i;
  logic        rd_last_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  logic [7:0]  bram [0:NPIX-1];
  logic [25:0] wr_q [$];
  logic [8:0]  rd_q [$];
  logic [25:0] w_exp;
  logic [8:0]  r_exp;

  int   cyc = 0;
  int   issued, xfers, writes_in_frame, done_cnt;
  int   first_rd_cyc, done_cyc;
  logic stall_prev = 1'b0;
  logic [7:0] stall_data;
  logic done_prev = 1'b0;

  frame_ctr_a #(.MAX_ROW(4), .MAX_COL(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .pixel_i    (pixel_i),
    .pixel_en_i (pixel_en_i),
    .ena_o      (ena_o),
    .wea_o      (wea_o),
    .addra_o    (addra_o),
    .d2mema_o   (d2mema_o),
    .mem2da_i   (mem2da_i),
    .rd_data_o  (rd_data_o),
    .rd_valid_o (rd_valid_o),
    .rd_ready_i (rd_ready_i),
    .rd_last_o  (rd_last_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  // Behavioural single-port BRAM with one cycle of read latency.
  always @(posedge clk) begin
    if (ena_o && wea_o) bram[addra_o[3:0]] <= d2mema_o;
    if (ena_o && !wea_o) mem2da_i <= bram[addra_o[3:0]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ena"}, ena_o, 0);
    chk({tag, "_wea"}, wea_o, 0);
    chk({tag, "_addra"}, addra_o, 0);
    chk({tag, "_d2mema"}, d2mema_o, 0);
    chk({tag, "_rd_data"}, rd_data_o, 0);
    chk({tag, "_rd_valid"}, rd_valid_o, 0);
    chk({tag, "_rd_last"}, rd_last_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_err"}, err_o, 0);
  endtask

  // Monitor: samples on the falling edge, pops expectations as the DUT presents them.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      stall_prev = 1'b0;
      done_prev  = 1'b0;
    end else begin
      if (ena_o && wea_o) begin
        if (wr_q.size() == 0) begin
          chk("unexpected_write", addra_o, 18'h3ffff);
        end else begin
          w_exp = wr_q.pop_front();
          chk("wr_addr", addra_o, w_exp[25:8]);
          chk("wr_data", d2mema_o, w_exp[7:0]);
        end
        writes_in_frame++;
      end
      if (busy_o && wea_o && !pixel_en_i) begin
        chk("fill_gap_ena", ena_o, 0);
        chk("fill_gap_data", d2mema_o, 0);
      end
      if (!busy_o && pixel_en_i) chk("idle_no_access", ena_o, 0);
      if (ena_o && !wea_o) begin
        if (issued == 0) begin
          first_rd_cyc = cyc;
          chk("read_after_full_fill", writes_in_frame, NPIX);
        end
        issued++;
      end
      if (stall_prev) begin
        chk("stall_valid", rd_valid_o, 1);
        chk("stall_data", rd_data_o, stall_data);
      end
      if (rd_valid_o && rd_ready_i) begin
        xfers++;
        if (rd_q.size() == 0) begin
          chk("unexpected_xfer", rd_valid_o, 0);
        end else begin
          r_exp = rd_q.pop_front();
          $display("xfer %0d data=%02h last=%0b exp=%02h/%0b", xfers, rd_data_o, rd_last_o, r_exp[7:0], r_exp[8]);
          chk("rd_data", rd_data_o, r_exp[7:0]);
          chk("rd_last", rd_last_o, r_exp[8]);
        end
      end
      if (ena_o && !wea_o) chk("outstanding_le2", (issued - xfers) <= 2, 1);
      stall_prev = rd_valid_o && !rd_ready_i;
      stall_data = rd_data_o;
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_single_cycle", done_prev, 0);
        chk("done_rd_q_empty", rd_q.size(), 0);
        chk("done_xfers", xfers, NPIX);
      end
      done_prev = done_o;
    end
  end

  task automatic run_frame(input bit rnd, input int gap, input int rmode,
                           input bit mid_start, input int abort_after, input logic exp_err);
    logic [7:0] pix;
    issued = 0; xfers = 0; writes_in_frame = 0; done_cnt = 0;
    first_rd_cyc = -1; done_cyc = -1;
    rd_ready_i = 1'b1;
    start_i = 1'b1;
    #1;
    chk("err_at_start", err_o, exp_err);
    chk("busy_before_start", busy_o, 0);
    tick();
    start_i = 1'b0;
    chk("err_after_start", err_o, 0);
    chk("busy_in_fill", busy_o, 1);
    for (int k = 0; k < NPIX; k++) begin
      repeat (gap) tick();
      pix = rnd ? 8'($urandom) : 8'(8'h10 + k);
      pixel_i    = pix;
      pixel_en_i = 1'b1;
      start_i    = mid_start && (k == 7);
      wr_q.push_back({18'(k), pix});
      rd_q.push_back({(k == NPIX - 1), pix});
      tick();
      pixel_en_i = 1'b0;
      start_i    = 1'b0;
      pixel_i    = 8'($urandom);
    end
    for (int c = 0; c < 400; c++) begin
      if (done_cnt > 0) break;
      if (abort_after > 0 && xfers >= abort_after) begin
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_read_reset");
        wr_q.delete();
        rd_q.delete();
        tick();
        rst = 1'b0;
        tick();
        return;
      end
      rd_ready_i = (rmode == 0) ? 1'b1 :
                   ((c >= 3 && c < 8) ? 1'b0 : 1'($urandom_range(0, 1)));
      tick();
    end
    chk("done_count", done_cnt, 1);
    chk("busy_after_done", busy_o, 0);
    chk("done_pulse_over", done_o, 0);
    chk("wr_q_drained", wr_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; pixel_en_i = 1'b0; pixel_i = 8'h00; rd_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst = 1'b0;
    tick();

    // Back-to-back pixels 0x10..0x1F with the consumer always ready.
    run_frame(1'b0, 0, 0, 1'b0, 0, 1'b0);
    chk("done_latency", done_cyc - first_rd_cyc, NPIX + 2);

    // Pixel every third cycle.
    run_frame(1'b1, 2, 0, 1'b0, 0, 1'b0);

    // Random backpressure including a 5-cycle stall.
    run_frame(1'b1, 0, 1, 1'b0, 0, 1'b0);

    // Stray pixels while idle raise err, cleared by the next start.
    pixel_i = 8'hAA;
    pixel_en_i = 1'b1;
    tick();
    tick();
    pixel_en_i = 1'b0;
    tick();
    chk("err_sticky_idle", err_o, 1);
    chk("idle_stays_idle", busy_o, 0);
    run_frame(1'b1, 1, 1, 1'b0, 0, 1'b1);

    // Start pulse during fill is ignored.
    run_frame(1'b1, 0, 0, 1'b1, 0, 1'b0);
    chk("mid_start_no_err", err_o, 0);

    // Reset after five transfers, then a clean frame.
    run_frame(1'b1, 0, 0, 1'b0, 5, 1'b0);
    chk("reset_mid_read_xfers", xfers, 5);
    run_frame(1'b1, 0, 1, 1'b0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
